led_bank_arbiter: RTL and testbench

- Shares the board's 8-LED bank between three requesters: Nios II LED PIO, a hardware status source and a diagnostic source.
- Round-robin arbitration with a per-grant time slot.
- Two debounced pushbuttons give manual "advance to next source" and "lock current source" controls.
- Sits in the top level between the requesters and the USE_LED pins, clocked from SYS_CLK (50 MHz).

---
 rtl/led_bank_arbiter.sv | 161 ++++++++++++++++
 tb/tb_led_bank_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the 8-LED bank across three requesters, with timed slots
// and debounced "advance" / "lock" pushbuttons.
module led_bank_arbiter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SLOT_CYCLES     = 25000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  src_req,
  input  logic [23:0] src_data,
  input  logic        pb_adv_n,
  input  logic        pb_lock_n,
  output logic [7:0]  led_out,
  output logic [2:0]  grant,
  output logic        locked,
  output logic        slot_expired
);

  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LOAD = CNT_W'(SLOT_CYCLES - 1);

  // Button conditioning: bit 0 = advance, bit 1 = lock.
  logic [1:0]       pb_raw, sync1, sync2, deb, press;
  logic [CNT_W-1:0] deb_cnt [2];
  logic             adv_p, lock_p;

  assign pb_raw = {pb_lock_n, pb_adv_n};
  assign adv_p  = press[0];
  assign lock_p = press[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1      <= '1;
      sync2      <= '1;
      deb        <= '1;
      press      <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync1 <= pb_raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i] <= '0;
          deb[i]     <= sync2[i];
          press[i]   <= ~sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Scan order last+1, last+2, last: the current owner is reached only when
  // nobody else requests, which gives the "keep if sole requester" rule.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] from);
    logic [1:0] sel;
    logic [1:0] idx;
    sel = from;
    for (int unsigned k = 0; k < 3; k++) begin
      idx = 2'((32'(from) + 3 - k) % 3);
      if (req[idx]) sel = idx;
    end
    return sel;
  endfunction

  state_t           state, state_d;
  logic [1:0]       last, last_d, pick;
  logic [CNT_W-1:0] slot_cnt, cnt_d;
  logic [2:0]       grant_d;
  logic             exp_d, locked_d, owner_req;
  logic [7:0]       led_d;

  assign pick      = rr_pick(src_req, last);
  assign owner_req = |(src_req & grant);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      last         <= 2'd2;
      slot_cnt     <= '0;
      grant        <= '0;
      led_out      <= '0;
      locked       <= 1'b0;
      slot_expired <= 1'b0;
    end else begin
      state        <= state_d;
      last         <= last_d;
      slot_cnt     <= cnt_d;
      grant        <= grant_d;
      led_out      <= led_d;
      locked       <= locked_d;
      slot_expired <= exp_d;
    end
  end

  always_comb begin
    state_d = state;
    last_d  = last;
    cnt_d   = slot_cnt;
    grant_d = grant;
    exp_d   = 1'b0;
    case (state)
      IDLE: begin
        if (|src_req) begin
          state_d = GRANT;
          grant_d = 3'b001 << pick;
          last_d  = pick;
          cnt_d   = SLOT_LOAD;
        end
      end
      GRANT, LOCKED: begin
        if (!owner_req) begin
          if (|src_req) begin
            state_d = GRANT;
            grant_d = 3'b001 << pick;
            last_d  = pick;
            cnt_d   = SLOT_LOAD;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (lock_p) begin
          if (state == GRANT) begin
            state_d = LOCKED;
          end else begin
            state_d = GRANT;
            cnt_d   = SLOT_LOAD;
          end
        end else if (state == GRANT) begin
          if (slot_cnt == '0 || adv_p) begin
            grant_d = 3'b001 << pick;
            last_d  = pick;
            cnt_d   = SLOT_LOAD;
            exp_d   = (slot_cnt == '0) && (pick != last);
          end else begin
            cnt_d = slot_cnt - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    locked_d = (state_d == LOCKED);
    case (grant)
      3'b001:  led_d = src_data[7:0];
      3'b010:  led_d = src_data[15:8];
      3'b100:  led_d = src_data[23:16];
      default: led_d = '0;
    endcase
  end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Bench for led_bank_arbiter: directed scenarios plus random traffic, all
// compared every cycle against a behavioural model of the arbitration rules.
module tb_led_bank_arbiter;

  localparam int unsigned D = 4;
  localparam int unsigned S = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  src_req;
  logic [23:0] src_data;
  logic        pb_adv_n, pb_lock_n;
  logic [7:0]  led_out;
  logic [2:0]  grant;
  logic        locked, slot_expired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_bank_arbiter #(.DEBOUNCE_CYCLES(D), .SLOT_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .src_req(src_req), .src_data(src_data),
    .pb_adv_n(pb_adv_n), .pb_lock_n(pb_lock_n), .led_out(led_out),
    .grant(grant), .locked(locked), .slot_expired(slot_expired)
  );

  // Behavioural model: owner index (-1 = nobody), slot cycles remaining,
  // and per-button raw sample history (index 0 = newest edge).
  int       m_owner, m_last, m_rem;
  bit       m_locked, m_exp;
  bit [7:0] m_led;
  bit [7:0] h_adv, h_lock;
  bit       d_adv, d_lock, m_p_adv, m_p_lock;

  function automatic int pick(input logic [2:0] req, input int from);
    for (int j = 1; j <= 3; j++)
      if (req[(from + j) % 3]) return (from + j) % 3;
    return -1;
  endfunction

  function automatic logic [2:0] oh(input int o);
    return (o < 0) ? 3'b000 : (3'b001 << o);
  endfunction

  function automatic logic [12:0] m_vec();
    return {m_led, oh(m_owner), m_locked, m_exp};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 2; m_rem = 0; m_locked = 0; m_exp = 0; m_led = 8'h00;
    h_adv = 8'hFF; h_lock = 8'hFF; d_adv = 1; d_lock = 1; m_p_adv = 0; m_p_lock = 0;
  endtask

  // A button level is accepted once D consecutive synchronised samples
  // (raw input two edges old) all disagree with the accepted level.
  task automatic deb_step(input bit raw, inout bit [7:0] h, inout bit deb, output bit p);
    bit all_diff;
    h = {h[6:0], raw};
    all_diff = 1;
    for (int j = 0; j < D; j++) if (h[2 + j] == deb) all_diff = 0;
    p = 0;
    if (all_diff) begin
      deb = h[2];
      p = !deb;
    end
  endtask

  task automatic model_step();
    int o;
    bit pa, pl;
    if (!reset_n) begin
      model_reset();
      return;
    end
    pa = m_p_adv;
    pl = m_p_lock;
    m_led = (m_owner < 0) ? 8'h00 : src_data[8*m_owner +: 8];
    m_exp = 0;
    o = pick(src_req, m_last);
    if (m_owner < 0) begin
      if (o >= 0) begin m_owner = o; m_last = o; m_rem = S - 1; end
    end else if (!src_req[m_owner]) begin
      m_locked = 0;
      m_owner = o;
      if (o >= 0) begin m_last = o; m_rem = S - 1; end
    end else if (pl) begin
      m_locked = !m_locked;
      if (!m_locked) m_rem = S - 1;
    end else if (!m_locked) begin
      if (m_rem == 0 || pa) begin
        m_exp = (m_rem == 0) && (o != m_owner);
        m_owner = o; m_last = o; m_rem = S - 1;
      end else begin
        m_rem--;
      end
    end
    deb_step(pb_adv_n, h_adv, d_adv, m_p_adv);
    deb_step(pb_lock_n, h_lock, d_lock, m_p_lock);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({led_out, grant, locked, slot_expired} !== 13'h0) begin
      errors++;
      $display("FAIL reset_values got %h exp %h", {led_out, grant, locked, slot_expired}, 13'h0);
    end
    reset_n = 1;
    repeat (3) begin
      tick();
      checks++;
      if ({led_out, grant, locked, slot_expired} !== m_vec()) begin
        errors++;
        $display("FAIL reset_idle t=%0t got %h exp %h", $time, {led_out, grant, locked, slot_expired}, m_vec());
      end
    end
  endtask

  task automatic test_single();
    src_req = 3'b001;
    src_data = {16'($urandom), 8'hA5};
    tick();
    checks++;
    if (grant !== 3'b001 || {led_out, grant, locked, slot_expired} !== m_vec()) begin
      errors++;
      $display("FAIL single_grant got %b exp %b", grant, 3'b001);
    end
    src_data = {16'($urandom), 8'hA5};
    tick();
    checks++;
    if (led_out !== 8'hA5 || {led_out, grant, locked, slot_expired} !== m_vec()) begin
      errors++;
      $display("FAIL single_led got %h exp %h", led_out, 8'hA5);
    end
    repeat (20) begin
      src_data = {16'($urandom), 8'hA5};
      tick();
      checks++;
      if (grant !== 3'b001 || slot_expired !== 1'b0 || {led_out, grant, locked, slot_expired} !== m_vec()) begin
        errors++;
        $display("FAIL single_hold t=%0t got %h exp %h", $time, {led_out, grant, locked, slot_expired}, m_vec());
      end
    end
  endtask

  task automatic test_rotation();
    int chg, pulses;
    logic [2:0] prev;
    chg = 0; pulses = 0;
    src_req = 3'b111;
    src_data = 24'h332211;
    prev = grant;
    repeat (32) begin
      tick();
      checks++;
      if ({led_out, grant, locked, slot_expired} !== m_vec()) begin
        errors++;
        $display("FAIL rotation t=%0t got %h exp %h", $time, {led_out, grant, locked, slot_expired}, m_vec());
      end
      if (grant !== prev) chg++;
      if (slot_expired === 1'b1) pulses++;
      prev = grant;
    end
    checks++;
    if (chg != 4 || pulses != 4) begin
      errors++;
      $display("FAIL rotation_count got changes=%0d pulses=%0d exp 4/4", chg, pulses);
    end
  endtask

  task automatic test_drop();
    int n;
    src_req = 3'b111;
    n = 0;
    while (!(m_owner == 1 && m_rem == 3) && n < 64) begin
      tick();
      n++;
      checks++;
      if ({led_out, grant, locked, slot_expired} !== m_vec()) begin
        errors++;
        $display("FAIL drop_wait t=%0t got %h exp %h", $time, {led_out, grant, locked, slot_expired}, m_vec());
      end
    end
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL drop_wait_timeout got %0d cycles exp <64", n);
    end
    src_req = 3'b101;
    tick();
    checks++;
    if (grant !== 3'b100 || {led_out, grant, locked, slot_expired} !== m_vec()) begin
      errors++;
      $display("FAIL drop_move got %b exp %b", grant, 3'b100);
    end
    repeat (7) begin
      tick();
      checks++;
      if (grant !== 3'b100 || {led_out, grant, locked, slot_expired} !== m_vec()) begin
        errors++;
        $display("FAIL drop_reload t=%0t got %b exp %b", $time, grant, 3'b100);
      end
    end
    src_req = 3'b000;
    tick();
    checks++;
    if (grant !== 3'b000 || {led_out, grant, locked, slot_expired} !== m_vec()) begin
      errors++;
      $display("FAIL drop_idle got %b exp %b", grant, 3'b000);
    end
    tick();
    checks++;
    if (led_out !== 8'h00 || {led_out, grant, locked, slot_expired} !== m_vec()) begin
      errors++;
      $display("FAIL drop_led got %h exp %h", led_out, 8'h00);
    end
  endtask

  task automatic test_adv_button();
    int n, chg, pulses;
    logic [2:0] prev;
    src_req = 3'b111;
    src_data = $urandom;
    n = 0;
    // Align to a fresh slot so the press lands mid-slot.
    while (!(m_owner >= 0 && m_rem == S - 1) && n < 32) begin
      tick();
      n++;
    end
    for (int i = 0; i < 8; i++) begin
      pb_adv_n = (i < 2) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if ({led_out, grant, locked, slot_expired} !== m_vec()) begin
        errors++;
        $display("FAIL adv_glitch t=%0t got %h exp %h", $time, {led_out, grant, locked, slot_expired}, m_vec());
      end
    end
    pb_adv_n = 0;
    chg = 0; pulses = 0;
    prev = grant;
    repeat (10) begin
      tick();
      checks++;
      if ({led_out, grant, locked, slot_expired} !== m_vec()) begin
        errors++;
        $display("FAIL adv_press t=%0t got %h exp %h", $time, {led_out, grant, locked, slot_expired}, m_vec());
      end
      if (grant !== prev) chg++;
      if (slot_expired === 1'b1) pulses++;
      prev = grant;
    end
    checks++;
    if (chg != 1 || pulses != 0) begin
      errors++;
      $display("FAIL adv_once got changes=%0d pulses=%0d exp 1/0", chg, pulses);
    end
    pb_adv_n = 1;
    repeat (10) begin
      tick();
      checks++;
      if ({led_out, grant, locked, slot_expired} !== m_vec()) begin
        errors++;
        $display("FAIL adv_release t=%0t got %h exp %h", $time, {led_out, grant, locked, slot_expired}, m_vec());
      end
    end
  endtask

  task automatic test_lock();
    logic [2:0] g_lock;
    int n;
    src_req = 3'b111;
    pb_lock_n = 0;
    repeat (8) begin
      tick();
      checks++;
      if ({led_out, grant, locked, slot_expired} !== m_vec()) begin
        errors++;
        $display("FAIL lock_press t=%0t got %h exp %h", $time, {led_out, grant, locked, slot_expired}, m_vec());
      end
    end
    pb_lock_n = 1;
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_set got %b exp 1", locked);
    end
    g_lock = oh(m_owner);
    for (int i = 0; i < 40; i++) begin
      pb_adv_n = ((i % 16) < 8 && i < 24) ? 1'b0 : 1'b1;
      src_data = $urandom;
      tick();
      checks++;
      if (grant !== g_lock || locked !== 1'b1 || {led_out, grant, locked, slot_expired} !== m_vec()) begin
        errors++;
        $display("FAIL lock_hold t=%0t got %h exp %h", $time, {led_out, grant, locked, slot_expired}, m_vec());
      end
    end
    pb_lock_n = 0;
    n = 0;
    while (locked !== 1'b0 && n < 12) begin
      tick();
      n++;
      checks++;
      if ({led_out, grant, locked, slot_expired} !== m_vec()) begin
        errors++;
        $display("FAIL unlock_press t=%0t got %h exp %h", $time, {led_out, grant, locked, slot_expired}, m_vec());
      end
    end
    pb_lock_n = 1;
    n = 0;
    while (grant === g_lock && n < 20) begin
      tick();
      n++;
      checks++;
      if ({led_out, grant, locked, slot_expired} !== m_vec()) begin
        errors++;
        $display("FAIL unlock_run t=%0t got %h exp %h", $time, {led_out, grant, locked, slot_expired}, m_vec());
      end
    end
    checks++;
    if (n != S) begin
      errors++;
      $display("FAIL unlock_slot got %0d cycles exp %0d", n, S);
    end
  endtask

  task automatic test_drop_lock_reset();
    int n;
    logic [2:0] old;
    src_req = 3'b111;
    pb_lock_n = 0;
    n = 0;
    while (!m_p_lock && n < 12) begin
      tick();
      n++;
    end
    old = grant;
    src_req = 3'b111 & ~oh(m_owner);
    tick();
    checks++;
    if (locked !== 1'b0 || grant === old || {led_out, grant, locked, slot_expired} !== m_vec()) begin
      errors++;
      $display("FAIL drop_vs_lock got %h exp %h", {led_out, grant, locked, slot_expired}, m_vec());
    end
    pb_lock_n = 1;
    src_req = 3'b111;
    repeat (8) tick();
    pb_lock_n = 0;
    n = 0;
    while (!m_locked && n < 12) begin
      tick();
      n++;
    end
    pb_lock_n = 1;
    pb_adv_n = 0;
    repeat (3) tick();
    checks++;
    if (locked !== 1'b1 || {led_out, grant, locked, slot_expired} !== m_vec()) begin
      errors++;
      $display("FAIL reset_prelock got %h exp %h", {led_out, grant, locked, slot_expired}, m_vec());
    end
    reset_n = 0;
    #1;
    checks++;
    if ({led_out, grant, locked, slot_expired} !== 13'h0) begin
      errors++;
      $display("FAIL mid_reset got %h exp %h", {led_out, grant, locked, slot_expired}, 13'h0);
    end
    pb_adv_n = 1;
    repeat (3) tick();
    reset_n = 1;
    model_reset();
    tick();
    checks++;
    if (grant !== 3'b001 || {led_out, grant, locked, slot_expired} !== m_vec()) begin
      errors++;
      $display("FAIL first_after_reset got %b exp %b", grant, 3'b001);
    end
  endtask

  task automatic test_random();
    int hold_a, hold_l;
    hold_a = 0; hold_l = 0;
    repeat (500) begin
      if ($urandom_range(0, 15) == 0) src_req = 3'($urandom);
      src_data = 24'($urandom);
      if (hold_a == 0) begin pb_adv_n = ~pb_adv_n; hold_a = $urandom_range(1, 12); end
      else hold_a--;
      if (hold_l == 0) begin pb_lock_n = ~pb_lock_n; hold_l = $urandom_range(1, 16); end
      else hold_l--;
      tick();
      checks++;
      if ({led_out, grant, locked, slot_expired} !== m_vec()) begin
        errors++;
        $display("FAIL random t=%0t got %h exp %h", $time, {led_out, grant, locked, slot_expired}, m_vec());
      end
    end
  endtask

  initial begin
    reset_n = 0;
    src_req = 3'b000;
    src_data = 24'h0;
    pb_adv_n = 1;
    pb_lock_n = 1;
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_drop();
    test_adv_button();
    test_lock();
    test_drop_lock_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
